noc_link_arbiter: RTL and testbench
===================================

# noc_link_arbiter

Packet-level round-robin arbiter that shares one credit-based OpenPiton NoC output link among NUM_REQ val/rdy flit sources. It sits upstream of a credit-to-val/rdy receive converter (16-entry flit FIFO) and guarantees two things: no flit is sent without a downstream credit, and packets from different sources never interleave (wormhole lock from header to last flit).

## Interface
- NUM_REQ, 3: number of requesting sources, 2..8.
- DATA_WIDTH, 64: flit width; must equal the NoC `DATA_WIDTH`.
- CREDITS, 16: initial credit count; equals downstream FIFO depth.
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-source flit valid.
- req_data  in  NUM_REQ*DATA_WIDTH  per-source flit; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-source accept, combinational.
- link_valid  out  1  registered flit valid to the credit link.
- link_data  out  DATA_WIDTH  registered flit.
- link_yummy  in  1  credit return, one credit per cycle asserted.
- credit_err  out  1  sticky flag: a credit was returned while the counter was already at CREDITS.
- busy  out  1  high while a packet is locked (BODY state).

## Operation
- Header flit length field is bits [29:22] (8-bit payload-flit count, header excluded).
- Credit counter `cred`, width $clog2(CREDITS+1), reset value CREDITS.
  - Send only: cred-1. Yummy only: cred+1, saturating at CREDITS; an increment at CREDITS sets credit_err.
  - Send and yummy in the same cycle: cred unchanged, and credit_err is not set.
- can_send = (cred != 0).
- FSM states:
  - IDLE: arbitrate among req_valid. The grant goes to the first valid source at or after rr_ptr, searching upward with wrap-around.
    - The grant fires only when can_send is true. The granted source gets req_ready=1; the handshake transfers the header.
    - If length==0: stay in IDLE and set rr_ptr = grant+1 (mod NUM_REQ).
    - Otherwise: latch owner=grant and remaining=length, then go to BODY.
  - BODY: req_ready[owner] = can_send; every other source's req_ready is 0.
    - Each handshake decrements remaining.
    - The handshake with remaining==1 is the last flit: go to IDLE and set rr_ptr = owner+1 (mod NUM_REQ).
    - A stall on the owner (req_valid low) holds the lock indefinitely; other sources are not served.
- req_ready is never asserted when cred==0. At most one req_ready bit is high in any cycle.
- A handshake loads link_data with the accepted flit and sets link_valid=1 for the next cycle. Otherwise link_valid=0 next cycle. There is no back-pressure on the link side; credits are the only flow control.
- Reset values: link_valid=0, link_data=0, cred=CREDITS, credit_err=0, state=IDLE, rr_ptr=0, owner=0, remaining=0, busy=0.
- Reset mid-packet drops the partial packet. The downstream FIFO is reset in the same domain.

## Timing
- Latency is 1 cycle: a handshake at edge N produces link_valid/link_data from edge N through N+1.
- Throughput is 1 flit per cycle while cred>0.
- A credit returned in cycle N is usable for a send in cycle N+1. It is not usable in the same cycle, because can_send uses the registered cred.
- The switch between packets has no dead cycle: the IDLE grant can fire in the cycle after the last body flit.
- req_ready depends combinationally on req_valid (grant select), state and cred. Sources must not make req_valid depend on req_ready.

## Structure
- Shared package `noc_arb_pkg`:
  - state enum {IDLE, BODY};
  - constants for the length field: LEN_HI=29, LEN_LO=22.
- One sub-module, `rr_pick`: combinational round-robin picker. Inputs are a NUM_REQ request vector and the pointer. Outputs are a one-hot grant and a found flag.
- The remainder is the top: credit counter, FSM, output register.

## Test plan
- Single source, length 2, CREDITS=16: three flits appear on link_valid in consecutive cycles, one cycle after each handshake; cred ends at 13; busy is high for exactly 2 cycles.
- Sources 0 and 1 both offer length-3 packets continuously: the link carries all 4 flits of source 0, then all 4 of source 1, with no interleave. Source 0 is served again next (rr_ptr wraps).
- No yummy, source streams flits: exactly 16 flits are sent, then req_ready stays 0. One link_yummy pulse causes exactly one more flit, one cycle later.
- Simultaneous send and yummy at cred=5: cred stays 5 and credit_err stays 0. Yummy with no sends at cred=16: cred stays 16 and credit_err=1 sticky until reset.
- Owner stalls mid-packet (req_valid low for 4 cycles) while source 2 is valid: source 2 gets no req_ready until the owner's last flit completes.
- rst_n asserted during BODY: link_valid=0 immediately (async), cred=16, state IDLE. After release, a zero-length packet from source 1 passes as a single flit.

Source files
------------

// File: rtl/noc_link_arbiter_pkg.sv
// Shared types and header-field constants for the NoC link arbiter.
package noc_arb_pkg;

    // Arbiter FSM: IDLE arbitrates headers, BODY holds the wormhole lock.
    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } arb_state_e;

    // Payload-flit count in the header (header itself excluded).
    localparam int LEN_HI = 29;
    localparam int LEN_LO = 22;
    localparam int LEN_W  = LEN_HI - LEN_LO + 1;

endpackage

// File: rtl/noc_link_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, searching upward with wrap-around.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_found
);

    int          w_pos;
    logic [PW-1:0] w_idx;

    // Rotate the search start to i_ptr and take the first hit.
    always_comb begin
        o_gnt   = '0;
        o_found = 1'b0;
        w_pos   = 0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
            w_idx = PW'(w_pos);
            if (!o_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_link_arbiter.sv
// Packet-level round-robin arbiter onto one credit-based NoC link.
// Never sends without a credit; packets are locked from header to last flit.
module noc_link_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 64,
    parameter int CREDITS    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_link_valid,
    output logic [DATA_WIDTH-1:0]         o_link_data,
    input  logic                          i_link_yummy,
    output logic                          o_credit_err,
    output logic                          o_busy
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int PW = $clog2(NUM_REQ);

    arb_state_e          r_state;
    logic [CW-1:0]       r_cred;
    logic                r_err;
    logic [PW-1:0]       r_rr_ptr;
    logic [PW-1:0]       r_owner;
    logic [LEN_W-1:0]    r_rem;
    logic                r_busy;
    logic                r_link_valid;
    logic [DATA_WIDTH-1:0] r_link_data;

    logic [NUM_REQ-1:0]    w_gnt;
    logic                  w_found;
    logic [PW-1:0]         w_gnt_idx;
    logic [PW-1:0]         w_sel_idx;
    logic                  w_can_send;
    logic                  w_hs;
    logic [DATA_WIDTH-1:0] w_flit;
    logic [LEN_W-1:0]      w_len;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_gnt),
        .o_found (w_found)
    );

    // One-hot grant to index.
    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (w_gnt[i]) w_gnt_idx = PW'(i);
    end

    // Credits come from the registered counter, so a yummy helps next cycle.
    assign w_can_send = (r_cred != '0);

    // Ready: grant winner in IDLE, the lock owner in BODY; never without credit.
    always_comb begin
        o_req_ready = '0;
        if (w_can_send) begin
            if (r_state == IDLE) o_req_ready = w_gnt;
            else                 o_req_ready[r_owner] = 1'b1;
        end
    end

    assign w_sel_idx = (r_state == IDLE) ? w_gnt_idx : r_owner;
    assign w_hs      = |(o_req_ready & i_req_valid);
    assign w_flit    = i_req_data[w_sel_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_len     = w_flit[LEN_HI:LEN_LO];

    // Credit counter; simultaneous send and return cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cred <= CW'(CREDITS);
            r_err  <= 1'b0;
        end else begin
            case ({w_hs, i_link_yummy})
                2'b10:   r_cred <= r_cred - 1'b1;
                2'b01: begin
                    if (r_cred == CW'(CREDITS)) r_err  <= 1'b1;
                    else                        r_cred <= r_cred + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Wormhole FSM: header grant in IDLE, owner-only service in BODY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_rem    <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_hs) begin
                    if (w_len == '0) begin
                        r_rr_ptr <= ptr_inc(w_gnt_idx);
                    end else begin
                        r_owner <= w_gnt_idx;
                        r_rem   <= w_len;
                        r_state <= BODY;
                        r_busy  <= 1'b1;
                    end
                end
                BODY: if (w_hs) begin
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == LEN_W'(1)) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= ptr_inc(r_owner);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Link output register: one cycle after each handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_link_valid <= 1'b0;
            r_link_data  <= '0;
        end else begin
            r_link_valid <= w_hs;
            if (w_hs) r_link_data <= w_flit;
        end
    end

    assign o_link_valid = r_link_valid;
    assign o_link_data  = r_link_data;
    assign o_credit_err = r_err;
    assign o_busy       = r_busy;

    logic w_unused;
    assign w_unused = w_found;

endmodule

// File: tb/tb_noc_link_arbiter.sv
// Bench for noc_link_arbiter: reset checks, a grant table, directed corner
// sequences and a randomized run against a packet-level reference model.
module tb_noc_link_arbiter;

    localparam int NR = 3;
    localparam int DW = 64;
    localparam int CR = 16;

    logic               clk;
    logic               rst_n;
    logic [NR-1:0]      i_req_valid;
    logic [NR*DW-1:0]   i_req_data;
    logic [NR-1:0]      o_req_ready;
    logic               o_link_valid;
    logic [DW-1:0]      o_link_data;
    logic               i_link_yummy;
    logic               o_credit_err;
    logic               o_busy;

    noc_link_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CREDITS(CR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (i_req_valid),
        .i_req_data   (i_req_data),
        .o_req_ready  (o_req_ready),
        .o_link_valid (o_link_valid),
        .o_link_data  (o_link_data),
        .i_link_yummy (i_link_yummy),
        .o_credit_err (o_credit_err),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef logic [DW-1:0] flit_q_t[$];
    flit_q_t q[NR];
    flit_q_t exp_seq;
    flit_q_t act_seq;

    logic [NR-1:0] en;
    logic          yd;
    logic [NR-1:0] last_ready;
    int            lv_cnt;
    int            busy_cnt;
    int            occ;

    // Reference model: packet-level view of the link.
    int      m_cred, m_lock, m_rem, m_rr;
    logic    m_err;
    logic    exp_lv;
    logic [DW-1:0] exp_ld;

    typedef struct {
        int            pre;
        logic [NR-1:0] v;
        logic [NR-1:0] rdy;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] model_ready(input logic [NR-1:0] v);
        logic [NR-1:0] r;
        int idx;
        r = '0;
        if (m_cred == 0) return r;
        if (m_lock >= 0) begin
            r[m_lock] = 1'b1;
        end else begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_rr + k) % NR;
                if (v[idx]) begin
                    r[idx] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        m_cred = CR; m_lock = -1; m_rem = 0; m_rr = 0; m_err = 1'b0;
        exp_lv = 1'b0; exp_ld = '0; occ = 0;
        for (int i = 0; i < NR; i++) q[i].delete();
        en = '0; yd = 1'b0;
    endtask

    task automatic push_pkt(input int src, input int len);
        logic [DW-1:0] f;
        f = {$urandom, $urandom};
        f[29:22] = 8'(len);
        q[src].push_back(f);
        exp_seq.push_back(f);
        for (int b = 0; b < len; b++) begin
            f = {$urandom, $urandom};
            q[src].push_back(f);
            exp_seq.push_back(f);
        end
    endtask

    // One clock: drive sources from their queues, check ready before the
    // edge, advance the model and check the link after it.
    task automatic step();
        logic [NR-1:0] v, mr, hs;
        logic [7:0]    len;
        int g;
        @(negedge clk);
        v = '0;
        for (int i = 0; i < NR; i++) begin
            if (en[i] && q[i].size() > 0) begin
                v[i] = 1'b1;
                i_req_data[i*DW +: DW] = q[i][0];
            end else begin
                i_req_data[i*DW +: DW] = {$urandom, $urandom};
            end
        end
        i_req_valid  = v;
        i_link_yummy = yd;
        #1;
        mr = model_ready(v);
        chk("req_ready", {{(DW-NR){1'b0}}, o_req_ready}, {{(DW-NR){1'b0}}, mr});
        last_ready = o_req_ready;
        @(posedge clk);
        #1;
        hs = mr & v;
        g = -1;
        for (int i = 0; i < NR; i++) if (hs[i]) g = i;
        if (g >= 0) begin
            exp_ld = q[g].pop_front();
            exp_lv = 1'b1;
            if (m_lock < 0) begin
                len = exp_ld[29:22];
                if (len == 0) m_rr = (g + 1) % NR;
                else begin m_lock = g; m_rem = len; end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_rr = (m_lock + 1) % NR;
                    m_lock = -1;
                end
            end
        end else begin
            exp_lv = 1'b0;
        end
        if (g >= 0 && !yd) m_cred--;
        else if (g < 0 && yd) begin
            if (m_cred == CR) m_err = 1'b1;
            else m_cred++;
        end
        chk("link_valid", {63'd0, o_link_valid}, {63'd0, exp_lv});
        if (exp_lv) begin
            chk("link_data", o_link_data, exp_ld);
            occ++;
        end
        if (o_link_valid) begin
            lv_cnt++;
            act_seq.push_back(o_link_data);
        end
        if (o_busy) busy_cnt++;
        chk("busy", {63'd0, o_busy}, {63'd0, (m_lock >= 0)});
        chk("credit_err", {63'd0, o_credit_err}, {63'd0, m_err});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req_valid = '0;
        i_link_yummy = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_link_valid", {63'd0, o_link_valid}, 64'd0);
        chk("rst_link_data", o_link_data, 64'd0);
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_credit_err", {63'd0, o_credit_err}, 64'd0);
        chk("rst_cred", 64'(dut.r_cred), 64'(CR));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        i_req_valid = '0;
        i_req_data = '0;
        i_link_yummy = 1'b0;
        lv_cnt = 0;
        busy_cnt = 0;
        model_clear();

        // Grant table: optional zero-length packet moves rr_ptr, then probe.
        tbl[0]  = '{-1, 3'b000, 3'b000};
        tbl[1]  = '{-1, 3'b111, 3'b001};
        tbl[2]  = '{-1, 3'b110, 3'b010};
        tbl[3]  = '{-1, 3'b100, 3'b100};
        tbl[4]  = '{ 0, 3'b101, 3'b100};
        tbl[5]  = '{ 0, 3'b011, 3'b010};
        tbl[6]  = '{ 1, 3'b011, 3'b001};
        tbl[7]  = '{ 2, 3'b110, 3'b010};
        tbl[8]  = '{ 2, 3'b101, 3'b001};
        tbl[9]  = '{ 1, 3'b001, 3'b001};
        tbl[10] = '{ 1, 3'b010, 3'b010};
        for (int t = 0; t < 11; t++) begin
            do_reset();
            if (tbl[t].pre >= 0) begin
                push_pkt(tbl[t].pre, 0);
                en = NR'(1 << tbl[t].pre);
                step();
                en = '0;
            end
            @(negedge clk);
            i_req_valid = tbl[t].v;
            #1;
            chk("grant_table", {{(DW-NR){1'b0}}, o_req_ready}, {{(DW-NR){1'b0}}, tbl[t].rdy});
            i_req_valid = '0;
        end

        // Single source, length 2.
        do_reset();
        push_pkt(0, 2);
        en = 3'b001;
        lv_cnt = 0; busy_cnt = 0;
        repeat (4) step();
        chk("len2_flits", 64'(lv_cnt), 64'd3);
        chk("len2_busy_cycles", 64'(busy_cnt), 64'd2);
        chk("len2_cred", 64'(dut.r_cred), 64'd13);

        // Two sources, length 3 each, served whole and in turn.
        do_reset();
        exp_seq.delete(); act_seq.delete();
        push_pkt(0, 3);
        push_pkt(1, 3);
        push_pkt(0, 3);
        en = 3'b011;
        repeat (14) step();
        chk("rr_order_len", 64'(act_seq.size()), 64'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < act_seq.size(); i++)
            chk("rr_order_flit", act_seq[i], exp_seq[i]);

        // Credit exhaustion and one returned credit.
        do_reset();
        for (int i = 0; i < 20; i++) push_pkt(1, 0);
        en = 3'b010;
        lv_cnt = 0;
        repeat (20) step();
        chk("exhaust_count", 64'(lv_cnt), 64'd16);
        chk("exhaust_ready", {61'd0, last_ready}, 64'd0);
        yd = 1'b1;
        lv_cnt = 0;
        step();
        yd = 1'b0;
        chk("yummy_same_cycle_ready", {61'd0, last_ready}, 64'd0);
        chk("yummy_same_cycle_lv", 64'(lv_cnt), 64'd0);
        step();
        chk("yummy_next_ready", {61'd0, last_ready}, 64'd2);
        repeat (3) step();
        chk("yummy_one_flit", 64'(lv_cnt), 64'd1);

        // Send and yummy together at cred=5.
        do_reset();
        for (int i = 0; i < 12; i++) push_pkt(0, 0);
        en = 3'b001;
        repeat (11) step();
        chk("cred_at5", 64'(dut.r_cred), 64'd5);
        yd = 1'b1;
        step();
        yd = 1'b0;
        en = '0;
        chk("send_yummy_cred", 64'(dut.r_cred), 64'd5);
        chk("send_yummy_err", {63'd0, o_credit_err}, 64'd0);

        // Yummy with full credits: sticky error.
        do_reset();
        yd = 1'b1;
        step();
        yd = 1'b0;
        chk("overflow_cred", 64'(dut.r_cred), 64'(CR));
        repeat (3) step();
        chk("overflow_sticky", {63'd0, o_credit_err}, 64'd1);

        // Owner stall while source 2 waits.
        do_reset();
        push_pkt(0, 3);
        push_pkt(2, 0);
        en = 3'b101;
        repeat (2) step();
        en = 3'b100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_no_grant2", {63'd0, last_ready[2]}, 64'd0);
        end
        en = 3'b101;
        repeat (2) step();
        chk("stall_last_owner", {61'd0, last_ready}, 64'd1);
        step();
        chk("stall_then_grant2", {61'd0, last_ready}, 64'd4);

        // Async reset during BODY, then a zero-length packet from source 1.
        do_reset();
        push_pkt(0, 3);
        en = 3'b001;
        repeat (2) step();
        chk("pre_rst_lv", {63'd0, o_link_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_lv", {63'd0, o_link_valid}, 64'd0);
        chk("async_rst_busy", {63'd0, o_busy}, 64'd0);
        chk("async_rst_cred", 64'(dut.r_cred), 64'(CR));
        chk("async_rst_state", {63'd0, dut.r_state}, 64'd0);
        model_clear();
        i_req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        push_pkt(1, 0);
        en = 3'b010;
        lv_cnt = 0;
        repeat (3) step();
        chk("post_rst_single", 64'(lv_cnt), 64'd1);

        // Randomized traffic with a downstream FIFO returning credits.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int s = 0; s < NR; s++)
                if (q[s].size() < 8 && $urandom_range(0, 3) == 0)
                    push_pkt(s, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4));
            for (int s = 0; s < NR; s++) en[s] = ($urandom_range(0, 9) < 7);
            if (occ > 0 && $urandom_range(0, 2) != 0) begin
                yd = 1'b1;
                occ--;
            end else begin
                yd = 1'b0;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
